// File: rtl/pe_loader.sv
// pe_loader: streams one pass of filter and ifmap pixels into a PE's scratchpads.
// Optional backpressure statistic is enabled by defining PE_LOADER_STATS_EN.
module pe_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int S_WIDTH    = 5,
    parameter int F_WIDTH    = 6,
    parameter int U_WIDTH    = 3,
    parameter int p_WIDTH    = 5,
    parameter int q_WIDTH    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [S_WIDTH-1:0]    S,
    input  logic [F_WIDTH-1:0]    F,
    input  logic [U_WIDTH-1:0]    U,
    input  logic [p_WIDTH-1:0]    p,
    input  logic [q_WIDTH-1:0]    q,
    input  logic [DATA_WIDTH-1:0] ifmap_in,
    input  logic                  ifmap_in_valid,
    output logic                  ifmap_in_ready,
    input  logic [DATA_WIDTH-1:0] filter_in,
    input  logic                  filter_in_valid,
    output logic                  filter_in_ready,
    output logic [DATA_WIDTH-1:0] ifmap_pixel,
    output logic                  wr_ifmap,
    input  logic                  ifmap_spad_full,
    output logic [DATA_WIDTH-1:0] filter_pixel,
    output logic                  wr_filter,
    input  logic                  filter_spad_full,
    output logic [15:0]           stall_cycles
);

    localparam int FT_W  = p_WIDTH + q_WIDTH + S_WIDTH;
    localparam int IN_W  = q_WIDTH + S_WIDTH;
    localparam int SL_W  = U_WIDTH + q_WIDTH;
    localparam int PIX_W = (IN_W > SL_W) ? IN_W : SL_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef enum logic {
        PH_INIT,
        PH_SLIDE
    } phase_t;

    state_t             state_q, state_d;
    phase_t             phase_q, phase_d;
    logic [FT_W-1:0]    f_tgt_q, f_tgt_d;
    logic [FT_W-1:0]    f_cnt_q, f_cnt_d;
    logic               fdone_q, fdone_d;
    logic [PIX_W-1:0]   init_tgt_q, init_tgt_d;
    logic [PIX_W-1:0]   slide_tgt_q, slide_tgt_d;
    logic [F_WIDTH-1:0] f_len_q, f_len_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [F_WIDTH-1:0] slide_q, slide_d;
    logic               idone_q, idone_d;

    logic run;
    logic slide_idle;
    logic slide_step;
    logic zero_cfg;

    assign run        = (state_q == ST_RUN);
    assign slide_idle = (phase_q == PH_SLIDE) && (slide_tgt_q == '0);
    assign zero_cfg   = (S == '0) || (F == '0) || (p == '0) || (q == '0);

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    assign filter_in_ready = run & ~fdone_q & ~filter_spad_full;
    assign wr_filter       = filter_in_valid & filter_in_ready;
    assign filter_pixel    = filter_in;

    // A zero-length slide consumes its cycle without opening the port.
    assign ifmap_in_ready = run & ~idone_q & ~slide_idle & ~ifmap_spad_full;
    assign wr_ifmap       = ifmap_in_valid & ifmap_in_ready;
    assign ifmap_pixel    = ifmap_in;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        f_tgt_d     = f_tgt_q;
        f_cnt_d     = f_cnt_q;
        fdone_d     = fdone_q;
        init_tgt_d  = init_tgt_q;
        slide_tgt_d = slide_tgt_q;
        f_len_d     = f_len_q;
        pix_d       = pix_q;
        slide_d     = slide_q;
        idone_d     = idone_q;
        slide_step  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    phase_d     = PH_INIT;
                    f_tgt_d     = FT_W'(p) * FT_W'(q) * FT_W'(S);
                    init_tgt_d  = PIX_W'(IN_W'(q) * IN_W'(S));
                    slide_tgt_d = PIX_W'(SL_W'(U) * SL_W'(q));
                    f_len_d     = F;
                    f_cnt_d     = '0;
                    pix_d       = '0;
                    slide_d     = '0;
                    fdone_d     = zero_cfg;
                    idone_d     = zero_cfg;
                end
            end
            ST_RUN: begin
                if (fdone_q && idone_q) begin
                    state_d = ST_DONE;
                end
                if (wr_filter) begin
                    f_cnt_d = f_cnt_q + FT_W'(1);
                    if (f_cnt_q + FT_W'(1) == f_tgt_q) begin
                        fdone_d = 1'b1;
                    end
                end
                if (phase_q == PH_INIT) begin
                    if (wr_ifmap) begin
                        pix_d = pix_q + PIX_W'(1);
                        if (pix_q + PIX_W'(1) == init_tgt_q) begin
                            pix_d = '0;
                            if (f_len_q == F_WIDTH'(1)) begin
                                idone_d = 1'b1;
                            end else begin
                                phase_d = PH_SLIDE;
                            end
                        end
                    end
                end else if (!idone_q) begin
                    if (slide_idle) begin
                        slide_step = 1'b1;
                    end else if (wr_ifmap) begin
                        if (pix_q + PIX_W'(1) == slide_tgt_q) begin
                            slide_step = 1'b1;
                        end else begin
                            pix_d = pix_q + PIX_W'(1);
                        end
                    end
                    if (slide_step) begin
                        pix_d = '0;
                        if (slide_q == f_len_q - F_WIDTH'(2)) begin
                            idone_d = 1'b1;
                        end else begin
                            slide_d = slide_q + F_WIDTH'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_INIT;
            f_tgt_q     <= '0;
            f_cnt_q     <= '0;
            fdone_q     <= 1'b0;
            init_tgt_q  <= '0;
            slide_tgt_q <= '0;
            f_len_q     <= '0;
            pix_q       <= '0;
            slide_q     <= '0;
            idone_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            f_tgt_q     <= f_tgt_d;
            f_cnt_q     <= f_cnt_d;
            fdone_q     <= fdone_d;
            init_tgt_q  <= init_tgt_d;
            slide_tgt_q <= slide_tgt_d;
            f_len_q     <= f_len_d;
            pix_q       <= pix_d;
            slide_q     <= slide_d;
            idone_q     <= idone_d;
        end
    end

`ifdef PE_LOADER_STATS_EN
    logic [15:0] stall_q, stall_d;
    logic        stalled;

    assign stalled = run &&
                     ((ifmap_in_valid & ~idone_q & ifmap_spad_full) ||
                      (filter_in_valid & ~fdone_q & filter_spad_full));

    always_comb begin
        stall_d = stall_q;
        if (state_q == ST_IDLE && start) begin
            stall_d = '0;
        end else if (stalled && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule
